fetch_pc_gen: RTL and testbench

- Owns the architectural fetch PC register and is the consumer of the 3-bit PC_select code produced by next-PC selection logic.
- Each cycle it applies the select code to the candidate targets (predicted branch targets, jump target, recovery PC, branch-handler PC, sequential PC) to form the next PC.
- Presents the PC to the I-cache with a valid/ready handshake.
- On misprediction recovery it runs a squash sequence: bumps the fetch epoch and blanks fetch for a programmable number of cycles so in-flight I-cache data can be dropped downstream.

---
 rtl/fetch_pc_gen.sv | 103 ++++++++++
 tb/tb_fetch_pc_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register driven by the next-PC select code, with I-cache handshake and mispredict squash sequencing.
module fetch_pc_gen #(
    parameter int              PC_W       = 16,
    parameter int              FETCH_INC  = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              SQUASH_CYC = 1,
    parameter int              EPOCH_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         PC_select,
    input  logic [PC_W-1:0]    br_tgt_hi,
    input  logic [PC_W-1:0]    br_tgt_lo,
    input  logic [PC_W-1:0]    jump_tgt,
    input  logic [PC_W-1:0]    recovery_pc,
    input  logic [PC_W-1:0]    bhndlr_pc,
    input  logic               icache_ready,
    output logic [PC_W-1:0]    pc,
    output logic               pc_valid,
    output logic               fetch_fire,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               squash,
    output logic [15:0]        redirect_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, SQUASH} state_t;
    localparam logic [PC_W-1:0] INC = PC_W'(FETCH_INC);
    localparam logic [2:0]      SQ  = 3'(SQUASH_CYC);
    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, sel_tgt;
    logic                pc_valid_q, pc_valid_d, squash_q, squash_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [15:0]         redirect_cnt_q, redirect_cnt_d;
    logic [2:0]          sq_cnt_q, sq_cnt_d;
    assign fetch_fire = pc_valid_q && icache_ready && (PC_select inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    assign sel_tgt = PC_select == 3'd0 ? br_tgt_hi :
                     PC_select == 3'd1 ? br_tgt_lo :
                     PC_select == 3'd2 ? jump_tgt  :
                     PC_select == 3'd4 ? bhndlr_pc : pc_q + INC;
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pc_valid_d     = pc_valid_q;
        squash_d       = squash_q;
        epoch_d        = epoch_q;
        redirect_cnt_d = redirect_cnt_q;
        sq_cnt_d       = sq_cnt_q;
        if (state_q == IDLE) begin
            pc_d = RESET_PC;
            if (PC_select != 3'd7) begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
        end else if (PC_select == 3'd7) begin
            state_d    = IDLE;
            pc_d       = RESET_PC;
            pc_valid_d = 1'b0;
            squash_d   = 1'b0;
            sq_cnt_d   = '0;
        end else if (PC_select == 3'd3) begin
            // Recovery always wins over backpressure and restarts any squash in progress.
            state_d        = SQUASH;
            pc_d           = recovery_pc;
            pc_valid_d     = 1'b0;
            squash_d       = 1'b1;
            epoch_d        = epoch_q + EPOCH_W'(1);
            redirect_cnt_d = &redirect_cnt_q ? redirect_cnt_q : redirect_cnt_q + 16'd1;
            sq_cnt_d       = SQ;
        end else if (state_q == SQUASH) begin
            sq_cnt_d = sq_cnt_q - 3'd1;
            if (sq_cnt_q == 3'd1) begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
                squash_d   = 1'b0;
            end
        end else if (fetch_fire) begin
            pc_d = sel_tgt;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            pc_valid_q     <= 1'b0;
            squash_q       <= 1'b0;
            epoch_q        <= '0;
            redirect_cnt_q <= '0;
            sq_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_valid_q     <= pc_valid_d;
            squash_q       <= squash_d;
            epoch_q        <= epoch_d;
            redirect_cnt_q <= redirect_cnt_d;
            sq_cnt_q       <= sq_cnt_d;
        end
    end
    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign fetch_epoch  = epoch_q;
    assign squash       = squash_q;
    assign redirect_cnt = redirect_cnt_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed plus random stimulus against a cycle-level reference model, checked through a scoreboard queue.
module tb_fetch_pc_gen;
    localparam int SQ = 2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  PC_select;
    logic [15:0] br_tgt_hi, br_tgt_lo, jump_tgt, recovery_pc, bhndlr_pc;
    logic        icache_ready;
    logic [15:0] pc, redirect_cnt;
    logic        pc_valid, fetch_fire, squash;
    logic [2:0]  fetch_epoch;
    fetch_pc_gen #(.SQUASH_CYC(SQ)) dut (
        .clk(clk), .rst_n(rst_n), .PC_select(PC_select),
        .br_tgt_hi(br_tgt_hi), .br_tgt_lo(br_tgt_lo), .jump_tgt(jump_tgt),
        .recovery_pc(recovery_pc), .bhndlr_pc(bhndlr_pc), .icache_ready(icache_ready),
        .pc(pc), .pc_valid(pc_valid), .fetch_fire(fetch_fire), .fetch_epoch(fetch_epoch),
        .squash(squash), .redirect_cnt(redirect_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit chk_fire;
        bit fire;
        int pc;
        bit valid;
        int epoch;
        bit squash;
        int rcnt;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    // reference model state
    bit known = 0, m_idle = 1, m_valid = 0;
    int m_pc = 0, m_epoch = 0, m_rcnt = 0, m_left = 0;
    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, req);
        end
    endtask
    task automatic step(input bit r, input int sel, input bit rdy, input int t);
        exp_t e;
        bit fire;
        @(negedge clk);
        rst_n = r;
        PC_select = 3'(sel);
        icache_ready = rdy;
        br_tgt_hi = 16'($urandom); br_tgt_lo = 16'($urandom); jump_tgt = 16'($urandom);
        recovery_pc = 16'($urandom); bhndlr_pc = 16'($urandom);
        case (sel)
            0: br_tgt_hi = 16'(t);
            1: br_tgt_lo = 16'(t);
            2: jump_tgt = 16'(t);
            3: recovery_pc = 16'(t);
            4: bhndlr_pc = 16'(t);
            default: ;
        endcase
        fire = m_valid && rdy && (sel == 0 || sel == 1 || sel == 2 || sel == 4 || sel == 5);
        e.chk_fire = known;
        e.fire = fire;
        if (!r) begin
            m_pc = 0; m_valid = 0; m_epoch = 0; m_rcnt = 0; m_left = 0; m_idle = 1; known = 1;
        end else if (m_idle) begin
            m_pc = 0;
            if (sel != 7) begin m_idle = 0; m_valid = 1; end
        end else if (sel == 7) begin
            m_pc = 0; m_valid = 0; m_idle = 1; m_left = 0;
        end else if (sel == 3) begin
            m_pc = t & 16'hFFFF; m_valid = 0; m_left = SQ;
            m_epoch = (m_epoch + 1) % 8;
            m_rcnt = m_rcnt < 65535 ? m_rcnt + 1 : m_rcnt;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1;
        end else if (fire) begin
            m_pc = (sel == 5 ? m_pc + 4 : t) & 16'hFFFF;
        end
        e.pc = m_pc; e.valid = m_valid; e.epoch = m_epoch; e.squash = m_left > 0; e.rcnt = m_rcnt;
        sb.push_back(e);
    endtask
    initial begin : monitor
        exp_t e;
        bit f;
        forever begin
            @(negedge clk);
            #2 f = fetch_fire;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = sb.pop_front();
                if (e.chk_fire) chk("fetch_fire", int'(f), int'(e.fire));
                chk("pc", int'(pc), e.pc);
                chk("pc_valid", int'(pc_valid), int'(e.valid));
                chk("fetch_epoch", int'(fetch_epoch), e.epoch);
                chk("squash", int'(squash), int'(e.squash));
                chk("redirect_cnt", int'(redirect_cnt), e.rcnt);
            end
        end
    end
    initial begin : driver
        int sel;
        rst_n = 1'b0; PC_select = 3'd5; icache_ready = 1'b1;
        br_tgt_hi = '0; br_tgt_lo = '0; jump_tgt = '0; recovery_pc = '0; bhndlr_pc = '0;
        repeat (3) step(0, 5, 1, 0);
        step(1, 5, 1, 0);
        repeat (3) step(1, 5, 1, 0);
        step(1, 0, 1, 16'h0120);
        step(1, 1, 1, 16'h0200);
        step(1, 2, 1, 16'h0300);
        step(1, 4, 1, 16'h0400);
        step(1, 2, 1, 16'hFFFC);
        step(1, 5, 1, 0);
        step(1, 2, 0, 16'h0777);
        step(1, 6, 1, 0);
        step(1, 3, 0, 16'h0A00);
        step(1, 5, 0, 0);
        step(1, 5, 0, 0);
        step(1, 3, 0, 16'h0A00);
        step(1, 3, 0, 16'h0B00);
        repeat (3) step(1, 5, 0, 0);
        step(1, 2, 1, 16'h0300);
        step(1, 7, 1, 0);
        step(1, 5, 1, 0);
        step(1, 5, 1, 0);
        step(1, 3, 1, 16'h1234);
        step(1, 7, 1, 0);
        step(1, 6, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 15);
            sel = sel < 8 ? sel : (sel < 11 ? 5 : (sel < 13 ? 6 : (sel == 13 ? 3 : 2)));
            step($urandom_range(0, 99) != 0, sel, $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)));
        end
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_left at %0t: got %0d entries want 0", $time, sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
